// File: rtl/cpu_pkg.sv
// Shared widths, ALU codes, forwarding selects and the ID/EX register layout.
package cpu_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int CTRL_W  = 3;

    typedef enum logic [CTRL_W-1:0] {
        ALU_AND  = 3'b000,
        ALU_XOR  = 3'b001,
        ALU_SLL  = 3'b010,
        ALU_ADD  = 3'b011,
        ALU_SUB  = 3'b100,
        ALU_MUL  = 3'b101,
        ALU_ADDI = 3'b110,
        ALU_SRAI = 3'b111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    // Everything the ID/EX register carries for one instruction.
    typedef struct packed {
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic [RADDR_W-1:0] rs1;
        logic [RADDR_W-1:0] rs2;
        logic [RADDR_W-1:0] rd;
        logic [CTRL_W-1:0]  alu_ctrl;
        logic               alu_src;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
    } id_ex_t;

    // A bubble is an all-zero entry: no writes, rd x0, ALU op AND.
    localparam id_ex_t ID_EX_BUBBLE = '0;

    // A producer forwards only when it writes a non-x0 register matching the source.
    function automatic logic fwd_match(input logic               wr_en,
                                       input logic [RADDR_W-1:0] prod_rd,
                                       input logic [RADDR_W-1:0] src);
        return wr_en && (prod_rd != '0) && (prod_rd == src);
    endfunction

endpackage

// File: rtl/id_ex_operand_stage_fwd_sel.sv
// Picks the freshest source for one operand; EX/MEM is newer than MEM/WB so it wins.
module fwd_sel
    import cpu_pkg::*;
(
    input  logic [RADDR_W-1:0] rs,
    input  logic               exmem_reg_write,
    input  logic [RADDR_W-1:0] exmem_rd,
    input  logic               memwb_reg_write,
    input  logic [RADDR_W-1:0] memwb_rd,
    output fwd_sel_e           sel
);

    // Priority select: EX/MEM, then MEM/WB, else register-file value.
    always_comb begin
        sel = FWD_RF;
        if (fwd_match(exmem_reg_write, exmem_rd, rs)) begin
            sel = FWD_EXMEM;
        end else if (fwd_match(memwb_reg_write, memwb_rd, rs)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall detection.
module id_ex_operand_stage
    import cpu_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic [XLEN-1:0]    id_rs1_data_i,
    input  logic [XLEN-1:0]    id_rs2_data_i,
    input  logic [XLEN-1:0]    id_imm_i,
    input  logic [RADDR_W-1:0] id_rs1_i,
    input  logic [RADDR_W-1:0] id_rs2_i,
    input  logic [RADDR_W-1:0] id_rd_i,
    input  logic [CTRL_W-1:0]  id_alu_ctrl_i,
    input  logic               id_alu_src_i,
    input  logic               id_reg_write_i,
    input  logic               id_mem_read_i,
    input  logic               id_mem_write_i,
    input  logic               id_mem_to_reg_i,
    input  logic               exmem_reg_write_i,
    input  logic [RADDR_W-1:0] exmem_rd_i,
    input  logic [XLEN-1:0]    exmem_result_i,
    input  logic               memwb_reg_write_i,
    input  logic [RADDR_W-1:0] memwb_rd_i,
    input  logic [XLEN-1:0]    memwb_data_i,
    output logic [XLEN-1:0]    data1_o,
    output logic [XLEN-1:0]    data2_o,
    output logic [CTRL_W-1:0]  alu_ctrl_o,
    output logic [XLEN-1:0]    store_data_o,
    output logic [RADDR_W-1:0] ex_rd_o,
    output logic               ex_reg_write_o,
    output logic               ex_mem_read_o,
    output logic               ex_mem_write_o,
    output logic               ex_mem_to_reg_o,
    output logic               hazard_o
);

    id_ex_t             id_ex_reg;
    id_ex_t             id_ex_next;
    id_ex_t             id_in;
    logic               load_use;
    logic [RADDR_W-1:0] src_addr [2];
    logic [XLEN-1:0]    rf_val   [2];
    logic [XLEN-1:0]    fwd_val  [2];
    fwd_sel_e           sel      [2];

    assign id_in = '{
        rs1_data:   id_rs1_data_i,
        rs2_data:   id_rs2_data_i,
        imm:        id_imm_i,
        rs1:        id_rs1_i,
        rs2:        id_rs2_i,
        rd:         id_rd_i,
        alu_ctrl:   id_alu_ctrl_i,
        alu_src:    id_alu_src_i,
        reg_write:  id_reg_write_i,
        mem_read:   id_mem_read_i,
        mem_write:  id_mem_write_i,
        mem_to_reg: id_mem_to_reg_i
    };

    // A load in EX whose destination feeds the instruction in ID needs one bubble.
    // Once the bubble enters EX mem_read is clear, so the request drops by itself.
    assign load_use = id_ex_reg.mem_read && (id_ex_reg.rd != '0) &&
                      ((id_ex_reg.rd == id_rs1_i) || (id_ex_reg.rd == id_rs2_i));
    assign hazard_o = load_use && !stall_i;

    // Next-entry select: external hold beats bubble insertion, which beats a normal load.
    always_comb begin
        id_ex_next = id_in;
        if (stall_i) begin
            id_ex_next = id_ex_reg;
        end else if (flush_i || load_use) begin
            id_ex_next = ID_EX_BUBBLE;
        end
    end

    // ID/EX register; reset empties the stage.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            id_ex_reg <= ID_EX_BUBBLE;
        end else begin
            id_ex_reg <= id_ex_next;
        end
    end

    assign src_addr[0] = id_ex_reg.rs1;
    assign src_addr[1] = id_ex_reg.rs2;
    assign rf_val[0]   = id_ex_reg.rs1_data;
    assign rf_val[1]   = id_ex_reg.rs2_data;

    // One forwarding selector and operand mux per source register.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        fwd_sel u_fwd_sel (
            .rs              (src_addr[gi]),
            .exmem_reg_write (exmem_reg_write_i),
            .exmem_rd        (exmem_rd_i),
            .memwb_reg_write (memwb_reg_write_i),
            .memwb_rd        (memwb_rd_i),
            .sel             (sel[gi])
        );

        assign fwd_val[gi] = (sel[gi] == FWD_EXMEM) ? exmem_result_i :
                             (sel[gi] == FWD_MEMWB) ? memwb_data_i   :
                                                      rf_val[gi];
    end

    // The immediate goes through untouched; shift ops take their amount from its low bits.
    assign data1_o         = fwd_val[0];
    assign store_data_o    = fwd_val[1];
    assign data2_o         = id_ex_reg.alu_src ? id_ex_reg.imm : fwd_val[1];
    assign alu_ctrl_o      = id_ex_reg.alu_ctrl;
    assign ex_rd_o         = id_ex_reg.rd;
    assign ex_reg_write_o  = id_ex_reg.reg_write;
    assign ex_mem_read_o   = id_ex_reg.mem_read;
    assign ex_mem_write_o  = id_ex_reg.mem_write;
    assign ex_mem_to_reg_o = id_ex_reg.mem_to_reg;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage with a queue-based scoreboard.
module tb_id_ex_operand_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i, flush_i;
    logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic [2:0]  id_alu_ctrl_i;
    logic        id_alu_src_i, id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i;
    logic        exmem_reg_write_i, memwb_reg_write_i;
    logic [4:0]  exmem_rd_i, memwb_rd_i;
    logic [31:0] exmem_result_i, memwb_data_i;
    logic [31:0] data1_o, data2_o, store_data_o;
    logic [2:0]  alu_ctrl_o;
    logic [4:0]  ex_rd_o;
    logic        ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o, hazard_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] d1, d2, st;
        logic [2:0]  ctrl;
        logic [4:0]  rd;
        logic        rw, mr, mw, mtr, haz;
    } exp_t;

    exp_t sb[$];

    always #5 clk_i = ~clk_i;

    id_ex_operand_stage dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .stall_i           (stall_i),
        .flush_i           (flush_i),
        .id_rs1_data_i     (id_rs1_data_i),
        .id_rs2_data_i     (id_rs2_data_i),
        .id_imm_i          (id_imm_i),
        .id_rs1_i          (id_rs1_i),
        .id_rs2_i          (id_rs2_i),
        .id_rd_i           (id_rd_i),
        .id_alu_ctrl_i     (id_alu_ctrl_i),
        .id_alu_src_i      (id_alu_src_i),
        .id_reg_write_i    (id_reg_write_i),
        .id_mem_read_i     (id_mem_read_i),
        .id_mem_write_i    (id_mem_write_i),
        .id_mem_to_reg_i   (id_mem_to_reg_i),
        .exmem_reg_write_i (exmem_reg_write_i),
        .exmem_rd_i        (exmem_rd_i),
        .exmem_result_i    (exmem_result_i),
        .memwb_reg_write_i (memwb_reg_write_i),
        .memwb_rd_i        (memwb_rd_i),
        .memwb_data_i      (memwb_data_i),
        .data1_o           (data1_o),
        .data2_o           (data2_o),
        .alu_ctrl_o        (alu_ctrl_o),
        .store_data_o      (store_data_o),
        .ex_rd_o           (ex_rd_o),
        .ex_reg_write_o    (ex_reg_write_o),
        .ex_mem_read_o     (ex_mem_read_o),
        .ex_mem_write_o    (ex_mem_write_o),
        .ex_mem_to_reg_o   (ex_mem_to_reg_o),
        .hazard_o          (hazard_o)
    );

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic [2:0] ctrl, input logic src, input logic rw,
                          input logic mr, input logic mw, input logic mtr);
        id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
        id_rs1_data_i = d1; id_rs2_data_i = d2; id_imm_i = imm;
        id_alu_ctrl_i = ctrl; id_alu_src_i = src; id_reg_write_i = rw;
        id_mem_read_i = mr; id_mem_write_i = mw; id_mem_to_reg_i = mtr;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                           input logic mwr, input logic [4:0] mrd, input logic [31:0] mdata);
        exmem_reg_write_i = ew;  exmem_rd_i = erd; exmem_result_i = eres;
        memwb_reg_write_i = mwr; memwb_rd_i = mrd; memwb_data_i   = mdata;
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] st, input logic [2:0] ctrl, input logic [4:0] rd,
                            input logic rw, input logic mr, input logic mw, input logic mtr,
                            input logic haz);
        exp_t e;
        e.tag = tag; e.d1 = d1; e.d2 = d2; e.st = st; e.ctrl = ctrl; e.rd = rd;
        e.rw = rw; e.mr = mr; e.mw = mw; e.mtr = mtr; e.haz = haz;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input string field,
                       input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, expv);
        end
    endtask

    // Let combinational paths settle, then compare every output with the oldest expectation.
    task automatic check_out;
        exp_t e;
        #1;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected>0");
            return;
        end
        e = sb.pop_front();
        cmp(e.tag, "data1",      data1_o,                  e.d1);
        cmp(e.tag, "data2",      data2_o,                  e.d2);
        cmp(e.tag, "store_data", store_data_o,             e.st);
        cmp(e.tag, "alu_ctrl",   {29'd0, alu_ctrl_o},      {29'd0, e.ctrl});
        cmp(e.tag, "rd",         {27'd0, ex_rd_o},         {27'd0, e.rd});
        cmp(e.tag, "ctrl_bits",
            {28'd0, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o},
            {28'd0, e.rw, e.mr, e.mw, e.mtr});
        cmp(e.tag, "hazard",     {31'd0, hazard_o},        {31'd0, e.haz});
        $display("txn %-14s d1=%h d2=%h st=%h ctrl=%b rd=%0d haz=%b",
                 e.tag, data1_o, data2_o, store_data_o, alu_ctrl_o, ex_rd_o, hazard_o);
    endtask

    initial begin
        rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        set_fwd(0, 0, 0, 0, 0, 0);
        // Reset dominates a valid ADD r3 sitting on the ID inputs.
        set_id(1, 2, 3, 32'h11, 32'h22, 0, 3'b011, 0, 1, 0, 0, 0);
        repeat (2) tick;
        push_exp("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_out;

        // ADD r3 captured, then reset mid-stream clears it at once.
        rst_i = 1'b1;
        tick;
        push_exp("add_r3", 32'h11, 32'h22, 32'h22, 3'b011, 3, 1, 0, 0, 0, 0);
        check_out;
        set_id(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        rst_i = 1'b0;
        push_exp("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_out;
        tick;
        rst_i = 1'b1;

        // ADD r1, then ADD r2 = r1 + r1 with both producers holding r1.
        set_id(0, 0, 1, 0, 0, 0, 3'b011, 0, 1, 0, 0, 0);
        tick;
        set_id(1, 1, 2, 32'h5, 32'h5, 0, 3'b011, 0, 1, 0, 0, 0);
        tick;
        set_fwd(1, 1, 32'h10, 1, 1, 32'h20);
        push_exp("fwd_both", 32'h10, 32'h10, 32'h10, 3'b011, 2, 1, 0, 0, 0, 0);
        check_out;
        set_fwd(0, 1, 32'h10, 1, 1, 32'h20);
        push_exp("fwd_memwb", 32'h20, 32'h20, 32'h20, 3'b011, 2, 1, 0, 0, 0, 0);
        check_out;
        set_fwd(1, 7, 32'h10, 0, 1, 32'h20);
        push_exp("fwd_none", 32'h5, 32'h5, 32'h5, 3'b011, 2, 1, 0, 0, 0, 0);
        check_out;

        // x0 sources never take forwarded data.
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(0, 0, 6, 0, 0, 0, 3'b011, 0, 1, 0, 0, 0);
        tick;
        set_fwd(1, 0, 32'hFF, 1, 0, 32'hEE);
        push_exp("x0_nofwd", 0, 0, 0, 3'b011, 6, 1, 0, 0, 0, 0);
        check_out;
        set_fwd(0, 0, 0, 0, 0, 0);

        // LW r5 followed by a user of r5 on rs2: one hazard cycle, a bubble, then the user.
        set_id(0, 0, 5, 0, 0, 32'h8, 3'b011, 1, 1, 1, 0, 1);
        tick;
        set_id(6, 5, 7, 32'h66, 32'h77, 0, 3'b011, 0, 1, 0, 0, 0);
        push_exp("lw_hazard", 0, 32'h8, 0, 3'b011, 5, 1, 1, 0, 1, 1);
        check_out;
        tick;
        push_exp("lw_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_out;
        tick;
        push_exp("add_r7", 32'h66, 32'h77, 32'h77, 3'b011, 7, 1, 0, 0, 0, 0);
        check_out;

        // LW r9 held by stall with flush also high; the rs1 hazard stays masked while stalled.
        set_id(0, 0, 9, 32'h91, 32'h92, 32'h4, 3'b011, 1, 1, 1, 0, 1);
        tick;
        set_id(9, 0, 10, 32'hA1, 32'hA2, 0, 3'b100, 0, 1, 0, 0, 0);
        stall_i = 1'b1;
        flush_i = 1'b1;
        push_exp("stall_hold", 32'h91, 32'h4, 32'h92, 3'b011, 9, 1, 1, 0, 1, 0);
        check_out;
        for (int k = 0; k < 3; k++) begin
            tick;
            push_exp($sformatf("stall_hold%0d", k), 32'h91, 32'h4, 32'h92, 3'b011, 9, 1, 1, 0, 1, 0);
            check_out;
        end
        stall_i = 1'b0;
        push_exp("stall_drop", 32'h91, 32'h4, 32'h92, 3'b011, 9, 1, 1, 0, 1, 1);
        check_out;
        tick;
        push_exp("flush_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_out;
        flush_i = 1'b0;

        // ADDI r4 with negative immediate; rs1 comes from MEM/WB.
        set_id(2, 0, 4, 32'h33, 32'h55, 32'hFFFF_FFFC, 3'b110, 1, 1, 0, 0, 0);
        tick;
        set_fwd(0, 0, 0, 1, 2, 32'h8);
        push_exp("addi_r4", 32'h8, 32'hFFFF_FFFC, 32'h55, 3'b110, 4, 1, 0, 0, 0, 0);
        check_out;

        // Store: data2 is the offset, store data is rs2 forwarded from EX/MEM.
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 3, 0, 32'h100, 32'h200, 32'h10, 3'b011, 1, 0, 0, 1, 0);
        tick;
        set_fwd(1, 3, 32'hABCD, 1, 1, 32'h1234);
        push_exp("sw_fwd", 32'h1234, 32'h10, 32'hABCD, 3'b011, 0, 0, 0, 1, 0, 0);
        check_out;

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
